goe_tx_dispatch: RTL and testbench
==================================

# goe_tx_dispatch

Egress dispatcher directly downstream of the output engine. Accepts the engine's 134-bit packet stream plus per-packet valid flag, buffers whole packets, and forwards each to either the physical-port path or the CPU path based on the output-port field in the metadata word. Packets flagged invalid are consumed silently. Applies packet-granular backpressure upstream and honours almost-full from both egress paths.

## Interface
- CPU_PORT, 8'd0, metadata port id selecting the CPU path
- LMID, 8'd6, module id (reserved for the config chain; unused in datapath)
- clk  in  1  sole clock
- rst_n  in  1  reset, synchronous, active-low
- in_data_wr  in  1  word strobe from output engine
- in_data  in  134  [133:132] tag 01 head / 11 middle / 10 tail, [131:128] valid-byte info, [127:0] payload; head word is metadata, [57:50] = output port id
- in_valid_wr  in  1  per-packet flag strobe, coincident with or after the tail word
- in_valid  in  1  1 = forward, 0 = drop
- out_ready  out  1  registered; upstream may start a packet only while high
- port_data_wr, port_data[133:0], port_valid_wr, port_valid  out  1/134/1/1  port path
- port_alf  in  1  port path almost-full
- cpu_data_wr, cpu_data[133:0], cpu_valid_wr, cpu_valid  out  1/134/1/1  CPU path
- cpu_alf  in  1  CPU path almost-full
- ovf_err  out  1  sticky, set on any write to a full buffer

## Operation
- Data buffer: 256 x 134, show-ahead. Flag buffer: 64 x 1, show-ahead. Every in_data_wr writes a word; every in_valid_wr writes a flag. Writes to a full buffer are discarded and set ovf_err.
- out_ready = (data used < 126) && (flag used < 62), registered. The largest packet (129 words incl. metadata) always fits once started; upstream never pauses mid-packet for ready.
- Read FSM states: IDLE, SEND, DROP.
  - IDLE: flag buffer non-empty. Flag 0 -> pop flag, DROP. Flag 1 and head[57:50] == CPU_PORT -> wait while cpu_alf, else pop flag, SEND to CPU. Otherwise wait while port_alf, else pop flag, SEND to port.
  - SEND: pop one word per cycle, drive selected path's data_wr=1 and data=word; alf ignored once started. On tail word also drive valid_wr=1, valid=1; return to IDLE.
  - DROP: pop one word per cycle, no output; on tail return to IDLE.
- Non-selected path outputs hold 0. Output data is 0 whenever data_wr=0.
- A head word seen in SEND/DROP before any tail: treated as payload (no resync); buffer contents are trusted from upstream.

## Timing
- Reset: all outputs 0, out_ready 0, ovf_err 0, buffers emptied, FSM IDLE. out_ready rises the first cycle after rst_n goes high.
- Reset mid-packet: packet aborted, no tail or valid_wr emitted, buffers flushed.
- Latency: flag written at cycle T -> dispatch decision at T+1 -> metadata word on output at T+2.
- Throughput: one word/cycle inside a packet; exactly one idle cycle between consecutive packets.
- Simultaneous write and pop of a buffer: used count unchanged.
- Flag arriving while its packet is still being written is impossible by protocol (flag strobes no earlier than tail).

## Configuration
- GOE_TX_STATS_EN defined: three 32-bit wrapping counters port_pkt_cnt, cpu_pkt_cnt, drop_pkt_cnt exposed as outputs, each incrementing once per packet at tail (SEND tail or DROP tail); reset to 0.
- Undefined: counter ports and logic absent; datapath identical.

## Test plan
- 3-word packet, head[57:50]=8'h03, flag 1 -> port path receives 3 words starting T+2, port_valid_wr=1 on 3rd word, CPU outputs stay 0.
- 2-word packet, head[57:50]=CPU_PORT, flag 1, cpu_alf=1 for 10 cycles -> no output until cpu_alf falls, then 2 words on CPU path.
- Packet flag 0 followed by a valid port packet -> first consumed silently, second emitted; drop_pkt_cnt=1, port_pkt_cnt=1 (with GOE_TX_STATS_EN).
- Fill with 130 words and port_alf held 1 -> out_ready falls at used=126; release -> drains, out_ready returns 1; ovf_err stays 0.
- Forced writes with buffer full -> ovf_err=1, held until reset.
- rst_n low during SEND at word 2 of 5 -> outputs 0 next cycle, no valid_wr, out_ready 0 then 1 after release.

Source files
------------

// File: rtl/goe_tx_dispatch.sv
// Egress dispatcher: buffers whole packets from the output engine and forwards each to the port or CPU path.
// Define GOE_TX_STATS_EN to add per-path packet counters (port_pkt_cnt, cpu_pkt_cnt, drop_pkt_cnt).
module goe_tx_dispatch #(
  parameter logic [7:0] CPU_PORT = 8'd0,
  parameter logic [7:0] LMID     = 8'd6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_data_wr,
  input  logic [133:0] in_data,
  input  logic         in_valid_wr,
  input  logic         in_valid,
  output logic         out_ready,
  output logic         port_data_wr,
  output logic [133:0] port_data,
  output logic         port_valid_wr,
  output logic         port_valid,
  input  logic         port_alf,
  output logic         cpu_data_wr,
  output logic [133:0] cpu_data,
  output logic         cpu_valid_wr,
  output logic         cpu_valid,
  input  logic         cpu_alf,
  output logic         ovf_err
`ifdef GOE_TX_STATS_EN
  ,
  output logic [31:0]  port_pkt_cnt,
  output logic [31:0]  cpu_pkt_cnt,
  output logic [31:0]  drop_pkt_cnt
`endif
);

  localparam int unsigned DW     = 134;
  localparam int unsigned DDEPTH = 256;
  localparam int unsigned DAW    = 8;
  localparam int unsigned FDEPTH = 64;
  localparam int unsigned FAW    = 6;

  typedef enum logic [1:0] {IDLE, SEND, DROP} state_e;

  // Module id only matters to the config chain, not to this datapath.
  logic [7:0] unused_lmid;
  assign unused_lmid = LMID;

  logic [DW-1:0]     dmem [DDEPTH];
  logic [FDEPTH-1:0] fmem_q;
  logic [DAW-1:0]    d_wptr_q, d_rptr_q;
  logic [DAW:0]      d_used_q, d_used_d;
  logic [FAW-1:0]    f_wptr_q, f_rptr_q;
  logic [FAW:0]      f_used_q, f_used_d;

  state_e        state_q, state_d;
  logic          gap_q, sel_cpu_q, ovf_q, out_ready_q;
  logic          port_data_wr_q, port_valid_wr_q, port_valid_q;
  logic          cpu_data_wr_q, cpu_valid_wr_q, cpu_valid_q;
  logic [DW-1:0] port_data_q, cpu_data_q;

  logic          d_full, f_full, d_wr, f_wr, d_pop, f_pop;
  logic [DW-1:0] d_head;
  logic          f_head, head_tail, head_cpu;
  logic          start_send, start_drop, emit, emit_cpu, emit_port, emit_cpu_c, pkt_end;

  assign d_full    = (d_used_q == 9'(DDEPTH));
  assign f_full    = (f_used_q == 7'(FDEPTH));
  assign d_wr      = in_data_wr && !d_full;
  assign f_wr      = in_valid_wr && !f_full;
  assign d_head    = dmem[d_rptr_q];
  assign f_head    = fmem_q[f_rptr_q];
  assign head_tail = (d_head[133:132] == 2'b10);
  assign head_cpu  = (d_head[57:50] == CPU_PORT);

  // Dispatch decision pops the flag and the head word together so metadata leaves one cycle later.
  always_comb begin
    d_pop      = 1'b0;
    f_pop      = 1'b0;
    start_send = 1'b0;
    start_drop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!gap_q && (f_used_q != '0) && (d_used_q != '0)) begin
          if (!f_head)                                 start_drop = 1'b1;
          else if (head_cpu ? !cpu_alf : !port_alf)    start_send = 1'b1;
        end
      end
      SEND, DROP: d_pop = (d_used_q != '0);
      default: ;
    endcase
    if (start_send || start_drop) begin
      d_pop = 1'b1;
      f_pop = 1'b1;
    end
    emit       = start_send || ((state_q == SEND) && d_pop);
    emit_cpu   = start_send ? head_cpu : sel_cpu_q;
    emit_port  = emit && !emit_cpu;
    emit_cpu_c = emit && emit_cpu;
    pkt_end    = d_pop && head_tail;
    d_used_d   = d_used_q + 9'(d_wr) - 9'(d_pop);
    f_used_d   = f_used_q + 7'(f_wr) - 7'(f_pop);
    state_d    = state_q;
    if (start_send)      state_d = SEND;
    else if (start_drop) state_d = DROP;
    if (pkt_end)         state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (d_wr) dmem[d_wptr_q]   <= in_data;
    if (f_wr) fmem_q[f_wptr_q] <= in_valid;
  end

  // Control FSM, buffer pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      gap_q           <= 1'b0;
      sel_cpu_q       <= 1'b0;
      d_wptr_q        <= '0;
      d_rptr_q        <= '0;
      d_used_q        <= '0;
      f_wptr_q        <= '0;
      f_rptr_q        <= '0;
      f_used_q        <= '0;
      ovf_q           <= 1'b0;
      out_ready_q     <= 1'b0;
      port_data_wr_q  <= 1'b0;
      port_data_q     <= '0;
      port_valid_wr_q <= 1'b0;
      port_valid_q    <= 1'b0;
      cpu_data_wr_q   <= 1'b0;
      cpu_data_q      <= '0;
      cpu_valid_wr_q  <= 1'b0;
      cpu_valid_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= pkt_end;
      if (start_send) sel_cpu_q <= head_cpu;
      if (d_wr)  d_wptr_q <= d_wptr_q + 8'd1;
      if (d_pop) d_rptr_q <= d_rptr_q + 8'd1;
      if (f_wr)  f_wptr_q <= f_wptr_q + 6'd1;
      if (f_pop) f_rptr_q <= f_rptr_q + 6'd1;
      d_used_q        <= d_used_d;
      f_used_q        <= f_used_d;
      ovf_q           <= ovf_q || (in_data_wr && d_full) || (in_valid_wr && f_full);
      out_ready_q     <= (d_used_d < 9'd126) && (f_used_d < 7'd62);
      port_data_wr_q  <= emit_port;
      port_data_q     <= emit_port ? d_head : '0;
      port_valid_wr_q <= emit_port && head_tail;
      port_valid_q    <= emit_port && head_tail;
      cpu_data_wr_q   <= emit_cpu_c;
      cpu_data_q      <= emit_cpu_c ? d_head : '0;
      cpu_valid_wr_q  <= emit_cpu_c && head_tail;
      cpu_valid_q     <= emit_cpu_c && head_tail;
    end
  end

  assign out_ready     = out_ready_q;
  assign ovf_err       = ovf_q;
  assign port_data_wr  = port_data_wr_q;
  assign port_data     = port_data_q;
  assign port_valid_wr = port_valid_wr_q;
  assign port_valid    = port_valid_q;
  assign cpu_data_wr   = cpu_data_wr_q;
  assign cpu_data      = cpu_data_q;
  assign cpu_valid_wr  = cpu_valid_wr_q;
  assign cpu_valid     = cpu_valid_q;

`ifdef GOE_TX_STATS_EN
  logic [31:0] port_cnt_q, cpu_cnt_q, drop_cnt_q;

  // Each packet counts once, on the cycle its tail word is popped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      port_cnt_q <= '0;
      cpu_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (emit_port && head_tail)  port_cnt_q <= port_cnt_q + 32'd1;
      if (emit_cpu_c && head_tail) cpu_cnt_q  <= cpu_cnt_q + 32'd1;
      if (pkt_end && !emit)        drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign port_pkt_cnt = port_cnt_q;
  assign cpu_pkt_cnt  = cpu_cnt_q;
  assign drop_pkt_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_goe_tx_dispatch.sv
// Bench for goe_tx_dispatch: directed scenarios plus randomized packets checked by a per-path expected-word scoreboard.
module tb_goe_tx_dispatch;
  localparam logic [7:0] CPU_PORT = 8'd0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_data_wr = 1'b0, in_valid_wr = 1'b0, in_valid = 1'b0;
  logic [133:0] in_data = '0;
  logic         port_alf = 1'b0, cpu_alf = 1'b0;
  logic         out_ready, ovf_err;
  logic         port_data_wr, port_valid_wr, port_valid;
  logic         cpu_data_wr, cpu_valid_wr, cpu_valid;
  logic [133:0] port_data, cpu_data;
`ifdef GOE_TX_STATS_EN
  logic [31:0]  port_pkt_cnt, cpu_pkt_cnt, drop_pkt_cnt;
`endif

  goe_tx_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .in_data_wr(in_data_wr), .in_data(in_data),
    .in_valid_wr(in_valid_wr), .in_valid(in_valid),
    .out_ready(out_ready),
    .port_data_wr(port_data_wr), .port_data(port_data),
    .port_valid_wr(port_valid_wr), .port_valid(port_valid), .port_alf(port_alf),
    .cpu_data_wr(cpu_data_wr), .cpu_data(cpu_data),
    .cpu_valid_wr(cpu_valid_wr), .cpu_valid(cpu_valid), .cpu_alf(cpu_alf),
    .ovf_err(ovf_err)
`ifdef GOE_TX_STATS_EN
    , .port_pkt_cnt(port_pkt_cnt), .cpu_pkt_cnt(cpu_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [133:0] d; logic last; } exp_t;

  exp_t         exp_port[$], exp_cpu[$];
  logic [133:0] pkt_w[$];
  int           n_cmp = 0, n_fail = 0;
  bit           mon_en = 1'b0, rnd_alf = 1'b0;

  logic [136:0] port_v, cpu_v;
  assign port_v = {port_data_wr, port_data, port_valid_wr, port_valid};
  assign cpu_v  = {cpu_data_wr, cpu_data, cpu_valid_wr, cpu_valid};

  // Scoreboard: every emitted word must be the next expected one of its path, with the rules on gaps and alf.
  exp_t mon_e;
  bit   prev_last = 1'b0, port_first = 1'b1, cpu_first = 1'b1, p_alf_prev = 1'b0, c_alf_prev = 1'b0;
  always begin
    @(posedge clk); #2;
    if (mon_en) begin
      n_cmp++;
      if (prev_last && (port_data_wr || cpu_data_wr)) begin
        n_fail++; $display("FAIL gap_after_tail: port_wr=%b cpu_wr=%b required 0 0", port_data_wr, cpu_data_wr);
      end
      n_cmp++;
      if (port_data_wr && cpu_data_wr) begin n_fail++; $display("FAIL both_paths: both data_wr high, required at most one"); end
      if (port_data_wr) begin
        if (port_first) begin
          n_cmp++;
          if (p_alf_prev) begin n_fail++; $display("FAIL port_start_alf: packet started with port_alf=1 required 0"); end
        end
        n_cmp++;
        if (exp_port.size() == 0) begin n_fail++; $display("FAIL port_unexpected: got word %h required none", port_data); end
        else begin
          mon_e = exp_port.pop_front();
          if (port_v !== {1'b1, mon_e.d, mon_e.last, mon_e.last}) begin
            n_fail++; $display("FAIL port_word: got %h vwr=%b v=%b required %h vwr=%b", port_data, port_valid_wr, port_valid, mon_e.d, mon_e.last);
          end
        end
        port_first = port_valid_wr;
      end else begin
        n_cmp++;
        if (port_v !== '0) begin n_fail++; $display("FAIL port_idle: got %h required 0", port_v); end
      end
      if (cpu_data_wr) begin
        if (cpu_first) begin
          n_cmp++;
          if (c_alf_prev) begin n_fail++; $display("FAIL cpu_start_alf: packet started with cpu_alf=1 required 0"); end
        end
        n_cmp++;
        if (exp_cpu.size() == 0) begin n_fail++; $display("FAIL cpu_unexpected: got word %h required none", cpu_data); end
        else begin
          mon_e = exp_cpu.pop_front();
          if (cpu_v !== {1'b1, mon_e.d, mon_e.last, mon_e.last}) begin
            n_fail++; $display("FAIL cpu_word: got %h vwr=%b v=%b required %h vwr=%b", cpu_data, cpu_valid_wr, cpu_valid, mon_e.d, mon_e.last);
          end
        end
        cpu_first = cpu_valid_wr;
      end else begin
        n_cmp++;
        if (cpu_v !== '0) begin n_fail++; $display("FAIL cpu_idle: got %h required 0", cpu_v); end
      end
      prev_last = port_valid_wr || cpu_valid_wr;
    end else begin
      prev_last = 1'b0; port_first = 1'b1; cpu_first = 1'b1;
    end
    p_alf_prev = port_alf;
    c_alf_prev = cpu_alf;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
    if (rnd_alf) begin
      port_alf = ($urandom_range(3) == 0);
      cpu_alf  = ($urandom_range(3) == 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_data_wr = 1'b0; in_data = '0; in_valid_wr = 1'b0; in_valid = 1'b0;
    port_alf = 1'b0; cpu_alf = 1'b0;
    exp_port.delete(); exp_cpu.delete();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic mk_word(input logic [1:0] tag, input logic [7:0] port, output logic [133:0] w);
    w = {tag, 4'($urandom_range(15)), $urandom, $urandom, $urandom, $urandom};
    if (tag == 2'b01) w[57:50] = port;
  endtask

  // Upstream: wait for out_ready, stream the packet, strobe its flag fdly cycles after the tail.
  task automatic send_pkt(input int len, input logic [7:0] port, input logic flg, input int fdly);
    logic [133:0] w;
    exp_t e;
    int wt = 0;
    pkt_w.delete();
    while (out_ready !== 1'b1 && wt < 3000) begin cyc(); wt++; end
    n_cmp++;
    if (out_ready !== 1'b1) begin n_fail++; $display("FAIL out_ready_wait: got %b required 1 within 3000 cycles", out_ready); end
    for (int i = 0; i < len; i++) begin
      mk_word(i == 0 ? 2'b01 : (i == len - 1 ? 2'b10 : 2'b11), port, w);
      pkt_w.push_back(w);
      e.d = w; e.last = (i == len - 1);
      if (flg && mon_en) begin
        if (port == CPU_PORT) exp_cpu.push_back(e); else exp_port.push_back(e);
      end
      in_data_wr = 1'b1; in_data = w;
      if (i == len - 1 && fdly == 0) begin in_valid_wr = 1'b1; in_valid = flg; end
      cyc();
    end
    in_data_wr = 1'b0; in_data = '0; in_valid_wr = 1'b0; in_valid = 1'b0;
    if (fdly > 0) begin
      repeat (fdly - 1) cyc();
      in_valid_wr = 1'b1; in_valid = flg;
      cyc();
      in_valid_wr = 1'b0; in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int w = 0;
    while ((exp_port.size() != 0 || exp_cpu.size() != 0) && w < budget) begin cyc(); w++; end
    n_cmp++;
    if (exp_port.size() != 0 || exp_cpu.size() != 0) begin
      n_fail++; $display("FAIL drain_timeout: %0d port / %0d cpu words outstanding required 0", exp_port.size(), exp_cpu.size());
    end
    repeat (4) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    n_cmp++; if (out_ready !== 1'b0) begin n_fail++; $display("FAIL reset_out_ready: got %b required 0", out_ready); end
    n_cmp++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", ovf_err); end
    n_cmp++; if ({port_v, cpu_v} !== '0) begin n_fail++; $display("FAIL reset_outputs: port_wr=%b cpu_wr=%b required all 0", port_data_wr, cpu_data_wr); end
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b required 1", out_ready); end
`ifdef GOE_TX_STATS_EN
    n_cmp++;
    if ({port_pkt_cnt, cpu_pkt_cnt, drop_pkt_cnt} !== '0) begin n_fail++; $display("FAIL reset_counters: got %0d %0d %0d required 0", port_pkt_cnt, cpu_pkt_cnt, drop_pkt_cnt); end
`endif
  endtask

  task automatic test_port_pkt();
    logic [136:0] ev;
    mon_en = 1'b0;
    send_pkt(3, 8'h03, 1'b1, 0);
    n_cmp++; if (port_data_wr !== 1'b0) begin n_fail++; $display("FAIL port_decision_cycle: port_wr=%b required 0", port_data_wr); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      ev = {1'b1, pkt_w[i], i == 2, i == 2};
      n_cmp++; if (port_v !== ev) begin n_fail++; $display("FAIL port_pkt_w%0d: got %h required %h", i, port_v, ev); end
      n_cmp++; if (cpu_v !== '0) begin n_fail++; $display("FAIL port_pkt_cpu_quiet: got %h required 0", cpu_v); end
    end
    cyc();
    n_cmp++; if (port_v !== '0) begin n_fail++; $display("FAIL port_pkt_end: got %h required 0", port_v); end
  endtask

  task automatic test_cpu_alf();
    logic [136:0] ev;
    cpu_alf = 1'b1;
    send_pkt(2, CPU_PORT, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++;
      if (port_data_wr !== 1'b0 || cpu_data_wr !== 1'b0) begin n_fail++; $display("FAIL cpu_alf_hold: port_wr=%b cpu_wr=%b required 0 0", port_data_wr, cpu_data_wr); end
    end
    cpu_alf = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      ev = {1'b1, pkt_w[i], i == 1, i == 1};
      n_cmp++; if (cpu_v !== ev) begin n_fail++; $display("FAIL cpu_pkt_w%0d: got %h required %h", i, cpu_v, ev); end
      n_cmp++; if (port_v !== '0) begin n_fail++; $display("FAIL cpu_pkt_port_quiet: got %h required 0", port_v); end
    end
    cyc();
    n_cmp++; if (cpu_v !== '0) begin n_fail++; $display("FAIL cpu_pkt_end: got %h required 0", cpu_v); end
  endtask

  task automatic test_back_to_back();
    logic [133:0] a_w[$];
    logic [136:0] seq[$];
    port_alf = 1'b1;
    send_pkt(3, 8'h03, 1'b1, 0);
    a_w = pkt_w;
    send_pkt(2, 8'h0a, 1'b1, 0);
    for (int i = 0; i < 3; i++) seq.push_back({1'b1, a_w[i], i == 2, i == 2});
    seq.push_back('0);
    for (int i = 0; i < 2; i++) seq.push_back({1'b1, pkt_w[i], i == 1, i == 1});
    port_alf = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_cmp++; if (port_v !== seq[i]) begin n_fail++; $display("FAIL b2b_cycle%0d: got %h required %h", i, port_v, seq[i]); end
    end
  endtask

  task automatic test_drop_then_port();
    do_reset();
    mon_en = 1'b1;
    send_pkt(3, 8'h07, 1'b0, 1);
    send_pkt(2, 8'h05, 1'b1, 0);
    wait_drain(200);
`ifdef GOE_TX_STATS_EN
    n_cmp++; if (drop_pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL drop_cnt: got %0d required 1", drop_pkt_cnt); end
    n_cmp++; if (port_pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL port_cnt: got %0d required 1", port_pkt_cnt); end
    n_cmp++; if (cpu_pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL cpu_cnt: got %0d required 0", cpu_pkt_cnt); end
`endif
  endtask

  task automatic test_fill();
    logic [133:0] w;
    exp_t e;
    int i, len;
    do_reset();
    mon_en = 1'b1;
    port_alf = 1'b1;
    for (int k = 0; k < 130; k++) begin
      i   = (k < 100) ? k : k - 100;
      len = (k < 100) ? 100 : 30;
      mk_word(i == 0 ? 2'b01 : (i == len - 1 ? 2'b10 : 2'b11), (k < 100) ? 8'h03 : 8'h09, w);
      e.d = w; e.last = (i == len - 1);
      exp_port.push_back(e);
      in_data_wr = 1'b1; in_data = w;
      in_valid_wr = e.last; in_valid = e.last;
      cyc();
      in_valid_wr = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if (out_ready !== (k + 1 < 126)) begin n_fail++; $display("FAIL fill_ready_at_%0d: got %b required %b", k + 1, out_ready, (k + 1 < 126)); end
    end
    in_data_wr = 1'b0; in_data = '0;
    cyc();
    n_cmp++; if (out_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_held: got %b required 0", out_ready); end
    port_alf = 1'b0;
    wait_drain(500);
    n_cmp++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_return: got %b required 1", out_ready); end
    n_cmp++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL fill_ovf: got %b required 0", ovf_err); end
  endtask

  task automatic test_overflow();
    logic [133:0] w;
    mon_en = 1'b0;
    do_reset();
    for (int k = 0; k < 258; k++) begin
      mk_word(2'b11, 8'h00, w);
      in_data_wr = 1'b1; in_data = w;
      cyc();
      n_cmp++;
      if (ovf_err !== (k >= 256)) begin n_fail++; $display("FAIL data_ovf_at_%0d: got %b required %b", k + 1, ovf_err, (k >= 256)); end
    end
    in_data_wr = 1'b0; in_data = '0;
    repeat (5) cyc();
    n_cmp++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", ovf_err); end
    do_reset();
    n_cmp++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_reset: got %b required 0", ovf_err); end
    for (int k = 0; k < 65; k++) begin
      in_valid_wr = 1'b1; in_valid = 1'b1;
      cyc();
      n_cmp++;
      if (ovf_err !== (k >= 64)) begin n_fail++; $display("FAIL flag_ovf_at_%0d: got %b required %b", k + 1, ovf_err, (k >= 64)); end
    end
    in_valid_wr = 1'b0; in_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic [136:0] ev;
    mon_en = 1'b0;
    do_reset();
    send_pkt(5, 8'h04, 1'b1, 0);
    cyc();
    cyc();
    ev = {1'b1, pkt_w[1], 1'b0, 1'b0};
    n_cmp++; if (port_v !== ev) begin n_fail++; $display("FAIL mid_word1: got %h required %h", port_v, ev); end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_cmp++; if ({port_v, cpu_v} !== '0) begin n_fail++; $display("FAIL mid_reset_out%0d: port_wr=%b vwr=%b required 0", i, port_data_wr, port_valid_wr); end
      n_cmp++; if (out_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready%0d: got %b required 0", i, out_ready); end
    end
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b required 1", out_ready); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++; if ({port_v, cpu_v} !== '0) begin n_fail++; $display("FAIL mid_flushed%0d: port_wr=%b vwr=%b required 0", i, port_data_wr, port_valid_wr); end
    end
    mon_en = 1'b1;
    send_pkt(2, 8'h06, 1'b1, 0);
    wait_drain(100);
  endtask

  task automatic test_random();
    logic [7:0] port;
    do_reset();
    mon_en = 1'b1;
    rnd_alf = 1'b1;
    for (int p = 0; p < 40; p++) begin
      port = ($urandom_range(2) == 0) ? CPU_PORT : 8'($urandom_range(255, 1));
      send_pkt($urandom_range(10, 2), port, $urandom_range(3) != 0, $urandom_range(3));
      if ($urandom_range(3) == 0) repeat ($urandom_range(4, 1)) cyc();
    end
    wait_drain(3000);
    rnd_alf = 1'b0; port_alf = 1'b0; cpu_alf = 1'b0;
    mon_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_port_pkt();
    test_cpu_alf();
    test_back_to_back();
    test_drop_then_port();
    test_fill();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
